// File: rtl/regfile_dump_if.sv
// Read-port and output-stream bundle for regfile_dump.
// master = dumper side, slave = register file plus beat sink.
interface regfile_dump_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_last;

  modport master (
    output rd_addr,
    input  rd_data,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_index,
    output out_last
  );

  modport slave (
    input  rd_addr,
    output rd_data,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_index,
    input  out_last
  );
endinterface

// File: rtl/regfile_dump.sv
// Streams registers 0..NUM_REGS-1 out as valid/ready beats, one register read per FETCH.
// Define REGFILE_DUMP_CHECKSUM_EN to append an XOR checksum beat after the last register.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | rd_data for the pointer is captured into the output beat
// SEND  | beat presented, held until the sink accepts
// CKSUM | checksum beat presented, held until accepted (checksum build only)
module regfile_dump #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           busy,
  output logic           done,
  regfile_dump_if.master bus
);

`ifdef REGFILE_DUMP_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, SEND = 2'd2, CKSUM = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, SEND = 2'd2} state_t;
`endif

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              hs;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] acc;
`endif

  assign hs          = bus.out_valid && bus.out_ready;
  // The read address is the pointer itself, so it stays stable for the whole beat.
  assign bus.rd_addr = ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_index <= '0;
      bus.out_last  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      acc           <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= FETCH;
            ptr   <= '0;
            busy  <= 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            acc   <= '0;
`endif
          end
        end

        FETCH: begin
          bus.out_data  <= bus.rd_data;
          bus.out_index <= ptr;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          bus.out_last  <= 1'b0;
`else
          bus.out_last  <= (ptr == LAST_IDX);
`endif
          bus.out_valid <= 1'b1;
          state         <= SEND;
        end

        SEND: begin
          if (hs) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
            acc <= acc ^ bus.out_data;
`endif
            if (ptr == LAST_IDX) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
              // Fold the final data beat in directly so the checksum beat follows without a gap.
              bus.out_data  <= acc ^ bus.out_data;
              bus.out_index <= '0;
              bus.out_last  <= 1'b1;
              bus.out_valid <= 1'b1;
              state         <= CKSUM;
`else
              bus.out_valid <= 1'b0;
              busy          <= 1'b0;
              done          <= 1'b1;
              state         <= IDLE;
`endif
            end else begin
              bus.out_valid <= 1'b0;
              ptr           <= ptr + 1'b1;
              state         <= FETCH;
            end
          end
        end

`ifdef REGFILE_DUMP_CHECKSUM_EN
        CKSUM: begin
          if (hs) begin
            bus.out_valid <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b1;
            state         <= IDLE;
          end
        end
`endif

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: stimulus queues expected beats, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_regfile_dump;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic clk = 1'b0;
  logic rst, start, ready;
  logic busy, done;

  regfile_dump_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

  regfile_dump #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus_if.master)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] regs [NUM_REGS];
  assign bus_if.rd_data   = regs[bus_if.rd_addr];
  assign bus_if.out_ready = ready;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] index;
    logic              last;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int n_cmp = 0;
  int n_err = 0;
  int beats_seen = 0;
  int done_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a beat is taken on the edge following a negedge that shows valid&&ready.
  always @(negedge clk) begin
    if (!rst && bus_if.out_valid && bus_if.out_ready) begin
      beats_seen++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL beat_unexpected: got index %0d data 0x%08h, expected no beat",
                 bus_if.out_index, bus_if.out_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("beat_data",  bus_if.out_data,  mon_e.data);
        check("beat_index", 32'(bus_if.out_index), 32'(mon_e.index));
        check("beat_last",  32'(bus_if.out_last),  32'(mon_e.last));
      end
    end
    if (!rst && done) done_count++;
  end

  // Expected dump: reg 0 = 0, reg i = 0x1000+i, with reg 20 possibly overwritten.
  task automatic push_dump(input logic [31:0] d20, input logic [31:0] cks);
    beat_t b;
    for (int i = 0; i < NUM_REGS; i++) begin
      b.data  = (i == 0) ? 32'h0 : ((i == 20) ? d20 : 32'h0000_1000 + 32'(i));
      b.index = ADDR_W'(i);
      b.last  = (EXTRA == 0) && (i == NUM_REGS - 1);
      exp_q.push_back(b);
    end
    if (EXTRA != 0) begin
      b.data  = cks;
      b.index = '0;
      b.last  = 1'b1;
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_beats(input int n);
    int k;
    for (k = 0; k < 1000; k++) begin
      if (beats_seen >= n) break;
      @(posedge clk); #1;
    end
    if (beats_seen < n) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_beats_timeout: got %0d beats expected %0d", beats_seen, n);
    end
  endtask

  // Pulses start, then counts cycles (sampling cycle = cycle 1) to first valid and to done.
  task automatic run_dump(input string name, input int exp_done_cycles, input bit chk_first);
    int edges;
    int first_v;
    bit got;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges   = 0;
    first_v = -1;
    got     = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (bus_if.out_valid && first_v < 0) first_v = edges;
      if (done) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      edges++;
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_done_timeout: got no done expected done by cycle %0d", name, exp_done_cycles);
    end else begin
      if (chk_first) check({name, "_first_valid_cycle"}, 32'(first_v + 1), 32'd2);
      check({name, "_done_cycle"}, 32'(edges + 1), 32'(exp_done_cycles));
      check({name, "_busy_at_done"}, 32'(busy), 32'd0);
    end
    @(posedge clk); #1;
    check({name, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    for (int i = 0; i < NUM_REGS; i++) regs[i] = (i == 0) ? 32'h0 : 32'h0000_1000 + 32'(i);
    rst   = 1'b1;
    start = 1'b0;
    ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    check("rst_busy",      32'(busy),             32'd0);
    check("rst_done",      32'(done),             32'd0);
    check("rst_rd_addr",   32'(bus_if.rd_addr),   32'd0);
    check("rst_out_data",  bus_if.out_data,       32'd0);
    check("rst_out_index", 32'(bus_if.out_index), 32'd0);
    check("rst_out_last",  32'(bus_if.out_last),  32'd0);
    @(posedge clk); #1;

    // Full dump, sink always ready
    push_dump(32'h0000_1014, 32'h0000_1000);
    run_dump("full", 65 + EXTRA, 1'b1);
    check("full_beats", 32'(beats_seen), 32'(NUM_REGS + EXTRA));

    // Backpressure on beat 5 for 10 cycles
    base = beats_seen;
    push_dump(32'h0000_1014, 32'h0000_1000);
    fork
      run_dump("bp", 75 + EXTRA, 1'b0);
      begin
        wait_beats(base + 5);
        ready = 1'b0;
        @(posedge clk); #1;
        repeat (10) begin
          @(negedge clk);
          check("bp_hold_valid", 32'(bus_if.out_valid), 32'd1);
          check("bp_hold_data",  bus_if.out_data,       32'h0000_1005);
          check("bp_hold_index", 32'(bus_if.out_index), 32'd5);
          check("bp_hold_rdaddr", 32'(bus_if.rd_addr),  32'd5);
          @(posedge clk); #1;
        end
        ready = 1'b1;
      end
    join
    check("bp_beats", 32'(beats_seen - base), 32'(NUM_REGS + EXTRA));

    // Start pulsed while busy at beat 12
    base = beats_seen;
    push_dump(32'h0000_1014, 32'h0000_1000);
    fork
      run_dump("busy_start", 65 + EXTRA, 1'b0);
      begin
        wait_beats(base + 12);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    join
    repeat (10) @(posedge clk);
    #1;
    check("busy_start_idle", 32'(busy), 32'd0);
    check("busy_start_beats", 32'(beats_seen - base), 32'(NUM_REGS + EXTRA));
    check("busy_start_done_count", 32'(done_count), 32'd3);

    // Reset during beat 10, with start also high (reset wins)
    base = beats_seen;
    for (int i = 0; i < 10; i++) begin
      mon_e.data  = (i == 0) ? 32'h0 : 32'h0000_1000 + 32'(i);
      mon_e.index = ADDR_W'(i);
      mon_e.last  = 1'b0;
      exp_q.push_back(mon_e);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_beats(base + 10);
    @(posedge clk); #1;
    check("rstmid_beat10_valid", 32'(bus_if.out_valid), 32'd1);
    check("rstmid_beat10_index", 32'(bus_if.out_index), 32'd10);
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("rstmid_out_valid", 32'(bus_if.out_valid), 32'd0);
    check("rstmid_busy",      32'(busy),             32'd0);
    check("rstmid_done",      32'(done),             32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("rstmid_still_idle", 32'(busy), 32'd0);
    check("rstmid_no_done", 32'(done_count), 32'd3);
    check("rstmid_queue_empty", 32'(exp_q.size()), 32'd0);
    push_dump(32'h0000_1014, 32'h0000_1000);
    run_dump("restart", 65 + EXTRA, 1'b1);

    // Register 20 rewritten after beat 3
    base = beats_seen;
    push_dump(32'hDEAD_BEEF, 32'hDEAD_BEFB);
    fork
      run_dump("midwrite", 65 + EXTRA, 1'b0);
      begin
        wait_beats(base + 4);
        regs[20] = 32'hDEAD_BEEF;
      end
    join
    regs[20] = 32'h0000_1014;

    repeat (5) @(posedge clk);
    #1;
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_done_count", 32'(done_count), 32'd5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
